// File: rtl/procyon_rs_entry_replay.sv
// One reservation-station slot: holds a dispatched op, snoops the CDBs for operand wakeup,
// and stays allocated after issue until the execution unit completes or replays it.
module procyon_rs_entry_replay #(
    parameter int OPTN_DATA_WIDTH       = 32,
    parameter int OPTN_ROB_IDX_WIDTH    = 5,
    parameter int OPTN_CDB_DEPTH        = 2,
    parameter int OPTN_RS_DEPTH         = 16,
    parameter int OPTN_SRC_COUNT        = 2,
    parameter int OPTN_REPLAY_CNT_WIDTH = 3,
    parameter int PCYN_OP_WIDTH         = 5,
    parameter int PCYN_OP_IS_WIDTH      = 2,
    parameter int RS_IDX_WIDTH          = (OPTN_RS_DEPTH == 1) ? 1 : $clog2(OPTN_RS_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_flush,
    input  logic [OPTN_CDB_DEPTH-1:0]        i_cdb_en,
    input  logic [OPTN_DATA_WIDTH-1:0]       i_cdb_data [0:OPTN_CDB_DEPTH-1],
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]    i_cdb_tag [0:OPTN_CDB_DEPTH-1],
    input  logic                             i_reserve_en,
    input  logic                             i_dispatch_en,
    input  logic [PCYN_OP_WIDTH-1:0]         i_dispatch_op,
    input  logic [PCYN_OP_IS_WIDTH-1:0]      i_dispatch_op_is,
    input  logic [OPTN_DATA_WIDTH-1:0]       i_dispatch_imm,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]    i_dispatch_dst_tag,
    input  logic [OPTN_SRC_COUNT-1:0]        i_dispatch_src_rdy,
    input  logic [OPTN_DATA_WIDTH-1:0]       i_dispatch_src_data [0:OPTN_SRC_COUNT-1],
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]    i_dispatch_src_tag [0:OPTN_SRC_COUNT-1],
    input  logic                             i_issue_en,
    input  logic                             i_complete,
    input  logic                             i_replay,
    input  logic [OPTN_SRC_COUNT-1:0]        i_replay_src_mask,
    input  logic                             i_dispatching,
    input  logic                             i_removing,
    input  logic [RS_IDX_WIDTH-1:0]          i_rs_remove_entry_age,
    output logic                             o_ready,
    output logic                             o_rs_entry_empty,
    output logic                             o_rs_entry_issued,
    output logic [RS_IDX_WIDTH-1:0]          o_rs_entry_age,
    output logic [PCYN_OP_WIDTH-1:0]         o_rs_entry_op,
    output logic [PCYN_OP_IS_WIDTH-1:0]      o_rs_entry_op_is,
    output logic [OPTN_DATA_WIDTH-1:0]       o_rs_entry_imm,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]    o_rs_entry_tag,
    output logic [OPTN_DATA_WIDTH-1:0]       o_rs_entry_src_data [0:OPTN_SRC_COUNT-1],
    output logic [OPTN_REPLAY_CNT_WIDTH-1:0] o_rs_entry_replay_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        RESERVED,
        WAITING,
        ISSUED
    } state_t;

    state_t                          state;
    logic [OPTN_SRC_COUNT-1:0]       src_rdy;
    logic [OPTN_ROB_IDX_WIDTH-1:0]   src_tag [0:OPTN_SRC_COUNT-1];
    logic [OPTN_ROB_IDX_WIDTH-1:0]   lookup_tag [0:OPTN_SRC_COUNT-1];
    logic [OPTN_SRC_COUNT-1:0]       cdb_hit;
    logic [OPTN_DATA_WIDTH-1:0]      cdb_val [0:OPTN_SRC_COUNT-1];

    // While RESERVED the stored tags are stale, so match against the incoming dispatch tags.
    always_comb begin
        for (int unsigned s = 0; s < OPTN_SRC_COUNT; s++) begin
            lookup_tag[s] = (state == RESERVED) ? i_dispatch_src_tag[s] : src_tag[s];
            cdb_hit[s]    = 1'b0;
            cdb_val[s]    = '0;
            for (int unsigned c = 0; c < OPTN_CDB_DEPTH; c++) begin
                if (i_cdb_en[c] && (i_cdb_tag[c] == lookup_tag[s])) begin
                    cdb_hit[s] = 1'b1;
                    cdb_val[s] = i_cdb_data[c];
                end
            end
        end
    end

    assign o_ready           = (state == WAITING) && (&src_rdy);
    assign o_rs_entry_empty  = (state == EMPTY);
    assign o_rs_entry_issued = (state == ISSUED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= EMPTY;
            src_rdy               <= '0;
            o_rs_entry_replay_cnt <= '0;
            o_rs_entry_op         <= '0;
            o_rs_entry_op_is      <= '0;
            o_rs_entry_imm        <= '0;
            o_rs_entry_tag        <= '0;
            for (int unsigned s = 0; s < OPTN_SRC_COUNT; s++) begin
                o_rs_entry_src_data[s] <= '0;
                src_tag[s]             <= '0;
            end
        end else if (i_flush) begin
            state                 <= EMPTY;
            src_rdy               <= '0;
            o_rs_entry_replay_cnt <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (i_reserve_en) begin
                        state   <= RESERVED;
                        src_rdy <= '0;
                    end
                end
                RESERVED: begin
                    if (i_dispatch_en) begin
                        state                 <= WAITING;
                        o_rs_entry_op         <= i_dispatch_op;
                        o_rs_entry_op_is      <= i_dispatch_op_is;
                        o_rs_entry_imm        <= i_dispatch_imm;
                        o_rs_entry_tag        <= i_dispatch_dst_tag;
                        o_rs_entry_replay_cnt <= '0;
                        for (int unsigned s = 0; s < OPTN_SRC_COUNT; s++) begin
                            src_tag[s] <= i_dispatch_src_tag[s];
                            if (i_dispatch_src_rdy[s]) begin
                                src_rdy[s]             <= 1'b1;
                                o_rs_entry_src_data[s] <= i_dispatch_src_data[s];
                            end else if (cdb_hit[s]) begin
                                src_rdy[s]             <= 1'b1;
                                o_rs_entry_src_data[s] <= cdb_val[s];
                            end else begin
                                src_rdy[s]             <= 1'b0;
                                o_rs_entry_src_data[s] <= i_dispatch_src_data[s];
                            end
                        end
                    end
                end
                WAITING: begin
                    for (int unsigned s = 0; s < OPTN_SRC_COUNT; s++) begin
                        if (!src_rdy[s] && cdb_hit[s]) begin
                            src_rdy[s]             <= 1'b1;
                            o_rs_entry_src_data[s] <= cdb_val[s];
                        end
                    end
                    if (i_issue_en && o_ready) state <= ISSUED;
                end
                ISSUED: begin
                    if (i_replay) begin
                        state <= WAITING;
                        if (o_rs_entry_replay_cnt != '1) begin
                            o_rs_entry_replay_cnt <= o_rs_entry_replay_cnt + 1'b1;
                        end
                        // A rebroadcast landing in the replay cycle itself must not be lost.
                        for (int unsigned s = 0; s < OPTN_SRC_COUNT; s++) begin
                            if (i_replay_src_mask[s]) begin
                                src_rdy[s] <= cdb_hit[s];
                                if (cdb_hit[s]) o_rs_entry_src_data[s] <= cdb_val[s];
                            end
                        end
                    end else if (i_complete) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rs_entry_age <= '0;
        end else begin
            case ({i_dispatching, i_removing})
                2'b01: begin
                    if (o_rs_entry_age > i_rs_remove_entry_age) begin
                        o_rs_entry_age <= o_rs_entry_age - RS_IDX_WIDTH'(1);
                    end
                end
                2'b10: begin
                    o_rs_entry_age <= i_dispatch_en ? '0 : o_rs_entry_age + RS_IDX_WIDTH'(1);
                end
                2'b11: begin
                    if (i_dispatch_en) begin
                        o_rs_entry_age <= '0;
                    end else if (o_rs_entry_age < i_rs_remove_entry_age) begin
                        o_rs_entry_age <= o_rs_entry_age + RS_IDX_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_procyon_rs_entry_replay.sv
// Directed bench for procyon_rs_entry_replay: a spec-level model checked every cycle,
// plus literal expectations at key points of the scenario.
module tb_procyon_rs_entry_replay;

    localparam int DW = 32;
    localparam int TW = 5;
    localparam int CD = 2;
    localparam int SC = 2;
    localparam int AW = 4;

    localparam int P_EMPTY    = 0;
    localparam int P_RESERVED = 1;
    localparam int P_WAITING  = 2;
    localparam int P_ISSUED   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_flush;
    logic [CD-1:0]   i_cdb_en;
    logic [DW-1:0]   i_cdb_data [0:CD-1];
    logic [TW-1:0]   i_cdb_tag [0:CD-1];
    logic            i_reserve_en;
    logic            i_dispatch_en;
    logic [4:0]      i_dispatch_op;
    logic [1:0]      i_dispatch_op_is;
    logic [DW-1:0]   i_dispatch_imm;
    logic [TW-1:0]   i_dispatch_dst_tag;
    logic [SC-1:0]   i_dispatch_src_rdy;
    logic [DW-1:0]   i_dispatch_src_data [0:SC-1];
    logic [TW-1:0]   i_dispatch_src_tag [0:SC-1];
    logic            i_issue_en;
    logic            i_complete;
    logic            i_replay;
    logic [SC-1:0]   i_replay_src_mask;
    logic            i_dispatching;
    logic            i_removing;
    logic [AW-1:0]   i_rs_remove_entry_age;
    logic            o_ready;
    logic            o_rs_entry_empty;
    logic            o_rs_entry_issued;
    logic [AW-1:0]   o_rs_entry_age;
    logic [4:0]      o_rs_entry_op;
    logic [1:0]      o_rs_entry_op_is;
    logic [DW-1:0]   o_rs_entry_imm;
    logic [TW-1:0]   o_rs_entry_tag;
    logic [DW-1:0]   o_rs_entry_src_data [0:SC-1];
    logic [2:0]      o_rs_entry_replay_cnt;

    procyon_rs_entry_replay #(
        .OPTN_DATA_WIDTH(DW),
        .OPTN_ROB_IDX_WIDTH(TW),
        .OPTN_CDB_DEPTH(CD),
        .OPTN_RS_DEPTH(16),
        .OPTN_SRC_COUNT(SC),
        .OPTN_REPLAY_CNT_WIDTH(3),
        .PCYN_OP_WIDTH(5),
        .PCYN_OP_IS_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_cdb_en(i_cdb_en), .i_cdb_data(i_cdb_data), .i_cdb_tag(i_cdb_tag),
        .i_reserve_en(i_reserve_en), .i_dispatch_en(i_dispatch_en),
        .i_dispatch_op(i_dispatch_op), .i_dispatch_op_is(i_dispatch_op_is),
        .i_dispatch_imm(i_dispatch_imm), .i_dispatch_dst_tag(i_dispatch_dst_tag),
        .i_dispatch_src_rdy(i_dispatch_src_rdy), .i_dispatch_src_data(i_dispatch_src_data),
        .i_dispatch_src_tag(i_dispatch_src_tag),
        .i_issue_en(i_issue_en), .i_complete(i_complete), .i_replay(i_replay),
        .i_replay_src_mask(i_replay_src_mask),
        .i_dispatching(i_dispatching), .i_removing(i_removing),
        .i_rs_remove_entry_age(i_rs_remove_entry_age),
        .o_ready(o_ready), .o_rs_entry_empty(o_rs_entry_empty),
        .o_rs_entry_issued(o_rs_entry_issued), .o_rs_entry_age(o_rs_entry_age),
        .o_rs_entry_op(o_rs_entry_op), .o_rs_entry_op_is(o_rs_entry_op_is),
        .o_rs_entry_imm(o_rs_entry_imm), .o_rs_entry_tag(o_rs_entry_tag),
        .o_rs_entry_src_data(o_rs_entry_src_data),
        .o_rs_entry_replay_cnt(o_rs_entry_replay_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int            m_phase;
    bit [SC-1:0]   m_rdy;
    logic [DW-1:0] m_data [0:SC-1];
    logic [TW-1:0] m_tag  [0:SC-1];
    int            m_cnt;
    int            m_age;
    int            nage;
    int            ra;
    logic [4:0]    m_op;
    logic [1:0]    m_op_is;
    logic [DW-1:0] m_imm;
    logic [TW-1:0] m_dtag;
    bit            m_valid = 1'b0;
    logic [DW-1:0] hit_d;

    // Highest-numbered matching CDB wins: scan from the top down and stop at the first hit.
    function automatic bit cdb_lookup(input logic [TW-1:0] t, output logic [DW-1:0] d);
        d = '0;
        for (int c = CD - 1; c >= 0; c--) begin
            if (i_cdb_en[c] && i_cdb_tag[c] == t) begin
                d = i_cdb_data[c];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        nage = m_age;
        ra   = int'(i_rs_remove_entry_age);
        case ({i_dispatching, i_removing})
            2'b01: if (m_age > ra) nage = m_age - 1;
            2'b10: nage = i_dispatch_en ? 0 : (m_age + 1) % 16;
            2'b11: nage = i_dispatch_en ? 0 : ((m_age < ra) ? m_age + 1 : m_age);
            default: ;
        endcase
        if (rst) begin
            m_phase = P_EMPTY; m_rdy = '0; m_cnt = 0; nage = 0;
            m_op = '0; m_op_is = '0; m_imm = '0; m_dtag = '0;
        end else if (i_flush) begin
            m_phase = P_EMPTY; m_rdy = '0; m_cnt = 0;
        end else if (m_phase == P_EMPTY) begin
            if (i_reserve_en) begin m_phase = P_RESERVED; m_rdy = '0; end
        end else if (m_phase == P_RESERVED) begin
            if (i_dispatch_en) begin
                m_phase = P_WAITING; m_cnt = 0;
                m_op = i_dispatch_op; m_op_is = i_dispatch_op_is;
                m_imm = i_dispatch_imm; m_dtag = i_dispatch_dst_tag;
                for (int s = 0; s < SC; s++) begin
                    m_tag[s] = i_dispatch_src_tag[s];
                    if (i_dispatch_src_rdy[s]) begin
                        m_rdy[s] = 1'b1; m_data[s] = i_dispatch_src_data[s];
                    end else if (cdb_lookup(i_dispatch_src_tag[s], hit_d)) begin
                        m_rdy[s] = 1'b1; m_data[s] = hit_d;
                    end else begin
                        m_rdy[s] = 1'b0;
                    end
                end
            end
        end else if (m_phase == P_WAITING) begin
            if (i_issue_en && m_rdy == '1) m_phase = P_ISSUED;
            for (int s = 0; s < SC; s++) begin
                if (!m_rdy[s] && cdb_lookup(m_tag[s], hit_d)) begin
                    m_rdy[s] = 1'b1; m_data[s] = hit_d;
                end
            end
        end else begin
            if (i_replay) begin
                m_phase = P_WAITING;
                m_cnt   = (m_cnt < 7) ? m_cnt + 1 : 7;
                for (int s = 0; s < SC; s++) begin
                    if (i_replay_src_mask[s]) begin
                        m_rdy[s] = cdb_lookup(m_tag[s], hit_d);
                        if (m_rdy[s]) m_data[s] = hit_d;
                    end
                end
            end else if (i_complete) begin
                m_phase = P_EMPTY;
            end
        end
        m_age   = nage;
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", 64'(o_ready), 64'(m_phase == P_WAITING && m_rdy == '1));
            chk("empty", 64'(o_rs_entry_empty), 64'(m_phase == P_EMPTY));
            chk("issued", 64'(o_rs_entry_issued), 64'(m_phase == P_ISSUED));
            chk("age", 64'(o_rs_entry_age), 64'(m_age));
            chk("replay_cnt", 64'(o_rs_entry_replay_cnt), 64'(m_cnt));
            if (m_phase == P_WAITING || m_phase == P_ISSUED) begin
                chk("op", 64'(o_rs_entry_op), 64'(m_op));
                chk("op_is", 64'(o_rs_entry_op_is), 64'(m_op_is));
                chk("imm", 64'(o_rs_entry_imm), 64'(m_imm));
                chk("dst_tag", 64'(o_rs_entry_tag), 64'(m_dtag));
                for (int s = 0; s < SC; s++) begin
                    if (m_rdy[s]) chk($sformatf("src_data%0d", s), 64'(o_rs_entry_src_data[s]), 64'(m_data[s]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        rst = 1'b0; i_flush = 1'b0; i_cdb_en = '0;
        i_reserve_en = 1'b0; i_dispatch_en = 1'b0; i_dispatch_src_rdy = '0;
        i_issue_en = 1'b0; i_complete = 1'b0; i_replay = 1'b0; i_replay_src_mask = '0;
        i_dispatching = 1'b0; i_removing = 1'b0; i_rs_remove_entry_age = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic cdb(input int port, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        i_cdb_en[port] = 1'b1; i_cdb_tag[port] = tag; i_cdb_data[port] = data;
    endtask

    task automatic dispatch(input logic [SC-1:0] rdy, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [TW-1:0] t0, input logic [TW-1:0] t1);
        i_dispatch_en = 1'b1; i_dispatch_src_rdy = rdy;
        i_dispatch_src_data[0] = d0; i_dispatch_src_data[1] = d1;
        i_dispatch_src_tag[0] = t0;  i_dispatch_src_tag[1] = t1;
    endtask

    initial begin
        clear_inputs();
        i_dispatch_op = 5'd3; i_dispatch_op_is = 2'd1; i_dispatch_imm = 32'h1234; i_dispatch_dst_tag = 5'd9;
        for (int i = 0; i < CD; i++) begin i_cdb_data[i] = '0; i_cdb_tag[i] = '0; end
        for (int i = 0; i < SC; i++) begin i_dispatch_src_data[i] = '0; i_dispatch_src_tag[i] = '0; end
        rst = 1'b1;
        cyc();
        chk("lit_reset_empty", 64'(o_rs_entry_empty), 64'd1);
        chk("lit_reset_ready", 64'(o_ready), 64'd0);
        chk("lit_reset_age", 64'(o_rs_entry_age), 64'd0);

        // ignored controls while EMPTY
        i_issue_en = 1'b1; i_complete = 1'b1; i_dispatch_en = 1'b1;
        cyc();

        // late wakeup via CDB0
        i_reserve_en = 1'b1; cyc();
        dispatch(2'b01, 32'h11, 32'h0, 5'd2, 5'd5); i_dispatching = 1'b1; cyc();
        cyc();
        chk("lit_wait_not_ready", 64'(o_ready), 64'd0);
        cdb(0, 5'd5, 32'hAB); cyc();
        chk("lit_wake_ready", 64'(o_ready), 64'd1);
        chk("lit_wake_src0", 64'(o_rs_entry_src_data[0]), 64'h11);
        chk("lit_wake_src1", 64'(o_rs_entry_src_data[1]), 64'hAB);

        // issue, replay, rebroadcast
        i_issue_en = 1'b1; cyc();
        chk("lit_issued", 64'(o_rs_entry_issued), 64'd1);
        i_replay = 1'b1; i_replay_src_mask = 2'b10; cyc();
        chk("lit_replay_not_ready", 64'(o_ready), 64'd0);
        chk("lit_replay_cnt1", 64'(o_rs_entry_replay_cnt), 64'd1);
        cdb(1, 5'd5, 32'hEF); cyc();
        chk("lit_rebroadcast_ready", 64'(o_ready), 64'd1);
        chk("lit_rebroadcast_data", 64'(o_rs_entry_src_data[1]), 64'hEF);
        for (int i = 0; i < 8; i++) begin
            i_issue_en = 1'b1; cyc();
            i_replay = 1'b1; i_replay_src_mask = 2'b10; cdb(0, 5'd5, 32'h100 + 32'(i)); cyc();
        end
        chk("lit_replay_sat", 64'(o_rs_entry_replay_cnt), 64'd7);
        chk("lit_replay_capture_ready", 64'(o_ready), 64'd1);
        chk("lit_replay_capture_data", 64'(o_rs_entry_src_data[1]), 64'h107);

        // replay beats complete, then complete alone frees
        i_issue_en = 1'b1; cyc();
        i_complete = 1'b1; i_replay = 1'b1; cyc();
        chk("lit_both_not_empty", 64'(o_rs_entry_empty), 64'd0);
        chk("lit_both_ready", 64'(o_ready), 64'd1);
        i_issue_en = 1'b1; cyc();
        i_complete = 1'b1; cyc();
        chk("lit_complete_empty", 64'(o_rs_entry_empty), 64'd1);

        // dispatch-cycle wakeup, two CDBs matching
        i_reserve_en = 1'b1; cyc();
        dispatch(2'b01, 32'h22, 32'h0, 5'd1, 5'd7);
        cdb(0, 5'd7, 32'h99); cdb(1, 5'd7, 32'hCD); cyc();
        chk("lit_disp_wake_ready", 64'(o_ready), 64'd1);
        chk("lit_disp_wake_data", 64'(o_rs_entry_src_data[1]), 64'hCD);
        chk("lit_disp_cnt_clear", 64'(o_rs_entry_replay_cnt), 64'd0);

        // flushes
        i_flush = 1'b1; i_issue_en = 1'b1; cyc();
        chk("lit_flush_waiting", 64'(o_rs_entry_empty), 64'd1);
        i_reserve_en = 1'b1; cyc();
        i_flush = 1'b1; dispatch(2'b11, 32'h1, 32'h2, 5'd0, 5'd0); cyc();
        chk("lit_flush_reserved", 64'(o_rs_entry_empty), 64'd1);
        i_reserve_en = 1'b1; cyc();
        dispatch(2'b11, 32'h33, 32'h44, 5'd3, 5'd4); cyc();
        i_issue_en = 1'b1; cyc();
        i_replay = 1'b1; cyc();
        i_issue_en = 1'b1; cyc();
        chk("lit_pre_flush_cnt", 64'(o_rs_entry_replay_cnt), 64'd1);
        i_flush = 1'b1; i_complete = 1'b1; cyc();
        chk("lit_flush_issued", 64'(o_rs_entry_empty), 64'd1);
        chk("lit_flush_cnt", 64'(o_rs_entry_replay_cnt), 64'd0);
        i_flush = 1'b1; i_reserve_en = 1'b1; cyc();
        chk("lit_flush_over_reserve", 64'(o_rs_entry_empty), 64'd1);

        // reset mid-ISSUED
        i_reserve_en = 1'b1; cyc();
        dispatch(2'b11, 32'h55, 32'h66, 5'd3, 5'd4); i_dispatching = 1'b1; cyc();
        i_dispatching = 1'b1; cyc();
        i_issue_en = 1'b1; cyc();
        rst = 1'b1; cyc();
        chk("lit_rst_empty", 64'(o_rs_entry_empty), 64'd1);
        chk("lit_rst_issued", 64'(o_rs_entry_issued), 64'd0);
        chk("lit_rst_age", 64'(o_rs_entry_age), 64'd0);
        chk("lit_rst_imm", 64'(o_rs_entry_imm), 64'd0);

        // age rules
        i_dispatching = 1'b1; i_removing = 1'b1; i_rs_remove_entry_age = 4'd1; cyc();
        chk("lit_age_0_to_1", 64'(o_rs_entry_age), 64'd1);
        i_dispatching = 1'b1; cyc();
        i_dispatching = 1'b1; cyc();
        chk("lit_age_3", 64'(o_rs_entry_age), 64'd3);
        i_dispatching = 1'b1; i_removing = 1'b1; i_rs_remove_entry_age = 4'd1; cyc();
        chk("lit_age_hold_3", 64'(o_rs_entry_age), 64'd3);
        i_removing = 1'b1; i_rs_remove_entry_age = 4'd2; cyc();
        chk("lit_age_dec_2", 64'(o_rs_entry_age), 64'd2);
        i_removing = 1'b1; i_rs_remove_entry_age = 4'd3; cyc();
        chk("lit_age_no_dec", 64'(o_rs_entry_age), 64'd2);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
